// File: rtl/instr_encoder.sv
// Turns DP / LDR-STR / B field requests into 32-bit ARM words and streams them out with their byte address.
// Latency: one cycle from an accepted request to out_valid. Backpressure: req_ready drops only when the FIFO is full.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_class,
    input  logic [3:0]                 req_cond,
    input  logic [3:0]                 req_cmd,
    input  logic                       req_s,
    input  logic                       req_i,
    input  logic                       req_u,
    input  logic                       req_l,
    input  logic [3:0]                 req_rn,
    input  logic [3:0]                 req_rd,
    input  logic [3:0]                 req_rm,
    input  logic [23:0]                req_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_addr,
    output logic                       err_illegal,
    output logic [7:0]                 err_count,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_illegal_q, err_illegal_d;
    logic [7:0]    err_count_q, err_count_d;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        cmd_ok;
    logic        is_cmp;
    logic [11:0] src2;
    logic        xfer, push, pop;

    always_comb begin
        enc_word    = 32'h0;
        enc_illegal = 1'b0;
        cmd_ok      = 1'b0;
        is_cmp      = (req_cmd[3:1] == 3'b101);
        src2        = req_i ? {4'h0, req_imm[7:0]} : {8'h00, req_rm};
        case (req_cmd)
            4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1011: cmd_ok = 1'b1;
            default:                                               cmd_ok = 1'b0;
        endcase
        case (req_class)
            2'b00: begin
                // Compares never write Rd and always set flags.
                enc_word    = {req_cond, 2'b00, req_i, req_cmd, req_s | is_cmp, req_rn,
                               is_cmp ? 4'h0 : req_rd, src2};
                enc_illegal = !cmd_ok || (req_i && (req_imm[23:8] != 16'h0));
            end
            2'b01:   enc_word = {req_cond, 2'b01, 1'b0, 1'b1, req_u, 1'b0, 1'b0, req_l,
                                 req_rn, req_rd, req_imm[11:0]};
            2'b10:   enc_word = {req_cond, 4'b1010, req_imm};
            default: enc_illegal = 1'b1;
        endcase
        if (req_cond == 4'hF) enc_illegal = 1'b1;
    end

    assign req_ready = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign xfer      = req_valid && req_ready;
    assign push      = xfer && !enc_illegal;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        addr_d        = pop  ? addr_q + 32'd4  : addr_q;
        level_d       = level_q;
        if (push && !pop) level_d = level_q + 1'b1;
        if (pop && !push) level_d = level_q - 1'b1;
        err_illegal_d = xfer && enc_illegal;
        err_count_d   = (err_illegal_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            addr_q        <= BASE_ADDR;
            err_illegal_q <= 1'b0;
            err_count_q   <= 8'h00;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            addr_q        <= addr_d;
            err_illegal_q <= err_illegal_d;
            err_count_q   <= err_count_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by level_q.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= enc_word;
    end

    assign out_instr   = mem_q[rd_ptr_q];
    assign out_addr    = addr_q;
    assign err_illegal = err_illegal_q;
    assign err_count   = err_count_q;
    assign fifo_level  = level_q;
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decode path: builds 32-bit ARM instruction words from field-level requests (DP, LDR/STR, B) and streams them out for writing into instruction memory.
- Covers the same instruction subset the processor decodes: ADD, SUB, AND, ORR, CMP, CMN, LDR/STR with immediate offset, and B.
- Sits between a program generator / test sequencer and the instruction-memory write port.
- Contains a request handshake, an encoder, an output FIFO and an address counter.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.

Ports:
CLK  in  1  clock, rising edge.
RESETn  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted this cycle when req_valid is also high.
req_class  in  2  00 = DP, 01 = MEM, 10 = BR, 11 = illegal.
req_cond  in  4  condition field, bits [31:28].
req_cmd  in  4  DP opcode.
req_s  in  1  DP S bit.
req_i  in  1  DP immediate select.
req_u  in  1  MEM up/down.
req_l  in  1  MEM load (1) or store (0).
req_rn  in  4  Rn.
req_rd  in  4  Rd.
req_rm  in  4  Rm.
req_imm  in  24  immediate; DP uses [7:0], MEM uses [11:0], BR uses [23:0].
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer takes the head.
out_instr  out  32  encoded word at the FIFO head.
out_addr  out  32  byte address for out_instr.
err_illegal  out  1  one-cycle pulse on a rejected request.
err_count  out  8  count of rejected requests, saturating.
fifo_level  out  clog2(DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (RESETn low, asynchronous):
  - FIFO is emptied and out_valid = 0.
  - fifo_level = 0, out_addr = BASE_ADDR.
  - err_illegal = 0, err_count = 0.
  - Any partially issued stream is discarded.
- Request handshake:
  - req_ready = !full; it does not depend on out_ready.
  - A transfer occurs when req_valid && req_ready at a rising edge.
- Encoding is combinational from the request fields; the word is written into the FIFO on the transfer edge.
- Latency: out_valid rises the cycle after a transfer into an empty FIFO.
- DP (class 00):
  - Layout: {cond, 2'b00, I, cmd, S, Rn, Rd, src2}.
  - src2 = {4'h0, imm[7:0]} when I = 1, else {8'h00, Rm}.
  - CMP (1010) and CMN (1011) force S = 1 and Rd = 0.
  - Legal cmd values are 0100, 0010, 0000, 1100, 1010 and 1011 only.
- MEM (class 01):
  - Layout: {cond, 2'b01, 1'b0, 1'b1, U, 1'b0, 1'b0, L, Rn, Rd, imm[11:0]}, i.e. immediate offset, pre-indexed, word access, no writeback.
- BR (class 10):
  - Layout: {cond, 4'b1010, imm[23:0]}.
- Illegal requests:
  - Conditions: class 11; DP with an unsupported cmd; DP with I = 1 and imm[23:8] != 0; cond = 1111.
  - The request is still handshaken (consumed) but nothing is enqueued.
  - err_illegal pulses for one cycle; err_count increments and saturates at 255.
- Output handshake:
  - A pop occurs on out_valid && out_ready.
  - out_addr increments by 4 after each pop and wraps modulo 2^32.
  - Words leave in strict order of acceptance.
  - out_instr and out_addr stay stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - Allowed when the FIFO is neither empty nor full, and fifo_level is unchanged.
  - When full, req_ready is already low, so there is no same-cycle pass-through.
  - When empty, the push takes effect and out_valid rises the next cycle; there is no combinational bypass.
- fifo_level is registered and updates on the clock edge.

Test Plan:
- DP immediate: DP, cond E, I = 1, cmd 0100, S = 0, rn 2, rd 1, imm 5 -> out_instr 0xE2821005, out_addr 0x0, out_valid high one cycle after the transfer.
- MEM pair: LDR with rn 4, rd 3, U = 1, imm 8 -> 0xE5943008; then STR with U = 0 -> 0xE5043008 at address 0x4.
- Forced fields: CMP with req_s = 0, rd 7, rn 0, rm 1, I = 0 -> 0xE1500001. Branch with cond 0, imm 0xFFFFFE -> 0x0AFFFFFE.
- Back-pressure: hold out_ready = 0 and push 4 requests -> fifo_level 4, req_ready low, 5th request held. Release out_ready -> 5 words emitted in order at addresses 0x0, 0x4, 0x8, 0xC, 0x10.
- Errors: DP cmd 1111 -> err_illegal one-cycle pulse, err_count 1, fifo_level unchanged. DP with I = 1 and imm 0x100 -> err_count 2. Repeating 260 illegal requests -> err_count stuck at 255.
- Reset mid-stream: 2 words queued and out_ready = 0, drop RESETn asynchronously -> out_valid 0, fifo_level 0, out_addr BASE_ADDR with no clock edge needed; after release, the next push emits at BASE_ADDR.
